// File: rtl/alarm_clock_pkg.sv
// alarm_clock_pkg: shared types and BCD helpers for the multi-alarm clock.
//   alarm_state_t : ring FSM states
//   hhmm_t        : packed BCD HH:MM value (13 bits)
//   hhmm_valid()  : legal 24-hour BCD time check
//   hhmm_inc()    : advance a legal BCD time by one minute, 23:59 wraps to 00:00
package alarm_clock_pkg;

    localparam int unsigned HHMM_W = 13;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RING   = 2'd1,
        SNOOZE = 2'd2
    } alarm_state_t;

    typedef struct packed {
        logic [1:0] hr1;
        logic [3:0] hr0;
        logic [2:0] min1;
        logic [3:0] min0;
    } hhmm_t;

    // Every digit must be BCD, hour <= 23, minute <= 59.
    function automatic logic hhmm_valid(input hhmm_t t);
        logic ok;
        ok = (t.hr1 <= 2'd2) && (t.hr0 <= 4'd9) && (t.min1 <= 3'd5) && (t.min0 <= 4'd9);
        if ((t.hr1 == 2'd2) && (t.hr0 > 4'd3)) begin
            ok = 1'b0;
        end
        return ok;
    endfunction

    // Ripple the minute carry through the BCD digits.
    function automatic hhmm_t hhmm_inc(input hhmm_t t);
        hhmm_t n;
        n = t;
        if (t.min0 != 4'd9) begin
            n.min0 = t.min0 + 4'd1;
        end else begin
            n.min0 = 4'd0;
            if (t.min1 != 3'd5) begin
                n.min1 = t.min1 + 3'd1;
            end else begin
                n.min1 = 3'd0;
                if ((t.hr1 == 2'd2) && (t.hr0 == 4'd3)) begin
                    n.hr1 = 2'd0;
                    n.hr0 = 4'd0;
                end else if (t.hr0 == 4'd9) begin
                    n.hr0 = 4'd0;
                    n.hr1 = t.hr1 + 2'd1;
                end else begin
                    n.hr0 = t.hr0 + 4'd1;
                end
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/multi_alarm_clock_tick_gen.sv
// tick_gen: minute prescaler producing a one-cycle clock enable.
//   clk  : system clock
//   rst  : synchronous active-high reset
//   clr  : restart the count from 0 (time write)
//   tick : high for the cycle in which the count equals TICK_DIV-1
module tick_gen #(
    parameter int unsigned TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] cnt_q;

    assign tick = (cnt_q == CW'(TICK_DIV - 1));

    // Count 0..TICK_DIV-1; a clear overrides the wrap.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_q <= '0;
        end else if (tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/multi_alarm_clock.sv
// multi_alarm_clock: 24-hour BCD clock with N programmable alarms,
// snooze and auto-silence.
//   clk, rst                      : clock, synchronous active-high reset
//   wr_en, wr_addr                : write strobe; addr 0 = time, k = alarm slot k-1
//   wr_hr1/hr0/min1/min0, wr_alm_en : write value and alarm enable
//   snooze, stop                  : one-cycle user pulses
//   hr1/hr0/min1/min0             : current time, BCD, registered
//   ring, ring_id, snoozing       : alarm status, registered
module multi_alarm_clock
    import alarm_clock_pkg::*;
#(
    parameter int unsigned TICK_DIV   = 50_000_000,
    parameter int unsigned N_ALARMS   = 4,
    parameter int unsigned SNOOZE_MIN = 5,
    parameter int unsigned RING_MIN   = 3,
    localparam int unsigned AW = $clog2(N_ALARMS + 1),
    localparam int unsigned IW = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [1:0]    wr_hr1,
    input  logic [3:0]    wr_hr0,
    input  logic [2:0]    wr_min1,
    input  logic [3:0]    wr_min0,
    input  logic          wr_alm_en,
    input  logic          snooze,
    input  logic          stop,
    output logic [1:0]    hr1,
    output logic [3:0]    hr0,
    output logic [2:0]    min1,
    output logic [3:0]    min0,
    output logic          ring,
    output logic [IW-1:0] ring_id,
    output logic          snoozing
);

    localparam int unsigned RCW = $clog2(RING_MIN + 1);
    localparam int unsigned SCW = $clog2(SNOOZE_MIN + 1);

    hhmm_t               time_q;
    hhmm_t               time_d;
    hhmm_t               wr_val;
    hhmm_t               alm_q [N_ALARMS];
    logic [N_ALARMS-1:0] alm_en_q;

    alarm_state_t        state_q;
    logic                ring_q;
    logic                snoozing_q;
    logic [IW-1:0]       ring_id_q;
    logic [RCW-1:0]      ring_cnt_q;
    logic [SCW-1:0]      snz_cnt_q;

    logic                tick;
    logic                tick_eff;
    logic                wr_ok;
    logic                time_wr;
    logic                alm_wr;
    logic                ring_slot_off;
    logic                match_hit;
    logic [IW-1:0]       match_idx;

    // Write decode: an invalid value or out-of-range address is dropped whole.
    assign wr_val        = {wr_hr1, wr_hr0, wr_min1, wr_min0};
    assign wr_ok         = wr_en && hhmm_valid(wr_val);
    assign time_wr       = wr_ok && (wr_addr == '0);
    assign alm_wr        = wr_ok && (wr_addr != '0) && (wr_addr <= AW'(N_ALARMS));
    assign ring_slot_off = alm_wr && !wr_alm_en && (wr_addr == (AW'(ring_id_q) + AW'(1)));

    // A time write swallows a coincident tick, so it can never cause a match.
    assign tick_eff = tick && !time_wr;
    assign time_d   = hhmm_inc(time_q);

    tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick_gen (
        .clk (clk),
        .rst (rst),
        .clr (time_wr),
        .tick(tick)
    );

    // Lowest enabled slot equal to the upcoming time wins.
    always_comb begin
        match_hit = 1'b0;
        match_idx = '0;
        for (int i = int'(N_ALARMS) - 1; i >= 0; i--) begin
            if (alm_en_q[i] && (alm_q[i] == time_d)) begin
                match_hit = 1'b1;
                match_idx = IW'(i);
            end
        end
    end

    // Time of day.
    always_ff @(posedge clk) begin
        if (rst) begin
            time_q <= '0;
        end else if (time_wr) begin
            time_q <= wr_val;
        end else if (tick_eff) begin
            time_q <= time_d;
        end
    end

    // Alarm slot storage.
    always_ff @(posedge clk) begin
        if (rst) begin
            alm_en_q <= '0;
            for (int i = 0; i < int'(N_ALARMS); i++) begin
                alm_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(N_ALARMS); i++) begin
                if (alm_wr && (wr_addr == AW'(i + 1))) begin
                    alm_q[i]    <= wr_val;
                    alm_en_q[i] <= wr_alm_en;
                end
            end
        end
    end

    // Ring / snooze state machine with registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ring_q     <= 1'b0;
            snoozing_q <= 1'b0;
            ring_id_q  <= '0;
            ring_cnt_q <= '0;
            snz_cnt_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (tick_eff && match_hit) begin
                        state_q    <= RING;
                        ring_q     <= 1'b1;
                        ring_id_q  <= match_idx;
                        ring_cnt_q <= '0;
                    end
                end
                RING: begin
                    if (stop || ring_slot_off) begin
                        state_q <= IDLE;
                        ring_q  <= 1'b0;
                    end else if (snooze) begin
                        state_q    <= SNOOZE;
                        ring_q     <= 1'b0;
                        snoozing_q <= 1'b1;
                        snz_cnt_q  <= SCW'(SNOOZE_MIN);
                    end else if (tick_eff) begin
                        // Silence on the RING_MIN-th tick since entry.
                        if (ring_cnt_q == RCW'(RING_MIN - 1)) begin
                            state_q <= IDLE;
                            ring_q  <= 1'b0;
                        end else begin
                            ring_cnt_q <= ring_cnt_q + RCW'(1);
                        end
                    end
                end
                SNOOZE: begin
                    if (stop || ring_slot_off) begin
                        state_q    <= IDLE;
                        snoozing_q <= 1'b0;
                    end else if (tick_eff) begin
                        if (snz_cnt_q == SCW'(1)) begin
                            state_q    <= RING;
                            ring_q     <= 1'b1;
                            snoozing_q <= 1'b0;
                            ring_cnt_q <= '0;
                        end else begin
                            snz_cnt_q <= snz_cnt_q - SCW'(1);
                        end
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    ring_q     <= 1'b0;
                    snoozing_q <= 1'b0;
                end
            endcase
        end
    end

    assign hr1      = time_q.hr1;
    assign hr0      = time_q.hr0;
    assign min1     = time_q.min1;
    assign min0     = time_q.min0;
    assign ring     = ring_q;
    assign ring_id  = ring_id_q;
    assign snoozing = snoozing_q;

endmodule

// File: tb/tb_multi_alarm_clock.sv
// tb_multi_alarm_clock: scoreboard bench for multi_alarm_clock with a
// 4-cycle minute tick, 4 alarms, 2-minute snooze and 3-minute ring.
module tb_multi_alarm_clock;

    localparam int unsigned TD = 4;
    localparam int unsigned NA = 4;
    localparam int unsigned SM = 2;
    localparam int unsigned RM = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [1:0] wr_hr1;
    logic [3:0] wr_hr0;
    logic [2:0] wr_min1;
    logic [3:0] wr_min0;
    logic       wr_alm_en;
    logic       snooze;
    logic       stop;
    logic [1:0] hr1;
    logic [3:0] hr0;
    logic [2:0] min1;
    logic [3:0] min0;
    logic       ring;
    logic [1:0] ring_id;
    logic       snoozing;

    always #5 clk = ~clk;

    multi_alarm_clock #(
        .TICK_DIV  (TD),
        .N_ALARMS  (NA),
        .SNOOZE_MIN(SM),
        .RING_MIN  (RM)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_hr1   (wr_hr1),
        .wr_hr0   (wr_hr0),
        .wr_min1  (wr_min1),
        .wr_min0  (wr_min0),
        .wr_alm_en(wr_alm_en),
        .snooze   (snooze),
        .stop     (stop),
        .hr1      (hr1),
        .hr0      (hr0),
        .min1     (min1),
        .min0     (min0),
        .ring     (ring),
        .ring_id  (ring_id),
        .snoozing (snoozing)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string      tag;
        logic [12:0] t;
        logic        r;
        logic        id_chk;
        logic [1:0]  id;
        logic        s;
    } exp_t;

    exp_t sb_q[$];

    function automatic logic [12:0] bcd(input int h, input int m);
        return {2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic [12:0] t, input logic r,
                        input logic id_chk, input logic [1:0] id, input logic s);
        exp_t e;
        e.tag    = tag;
        e.t      = t;
        e.r      = r;
        e.id_chk = id_chk;
        e.id     = id;
        e.s      = s;
        sb_q.push_back(e);
    endtask

    task automatic push_idle(input string tag, input logic [12:0] t);
        push(tag, t, 1'b0, 1'b0, 2'd0, 1'b0);
    endtask

    // Compare the oldest outstanding expectation against the DUT outputs now.
    task automatic sb_pop();
        exp_t e;
        if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_underflow: got empty queue, expected an entry");
            return;
        end
        e = sb_q.pop_front();
        check({e.tag, ":time"}, 32'({hr1, hr0, min1, min0}), 32'(e.t));
        check({e.tag, ":ring"}, 32'(ring), 32'(e.r));
        check({e.tag, ":snoozing"}, 32'(snoozing), 32'(e.s));
        if (e.id_chk) begin
            check({e.tag, ":ring_id"}, 32'(ring_id), 32'(e.id));
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [1:0] h1, input logic [3:0] h0,
                      input logic [2:0] m1, input logic [3:0] m0, input logic en);
        wr_en     = 1'b1;
        wr_addr   = a;
        wr_hr1    = h1;
        wr_hr0    = h0;
        wr_min1   = m1;
        wr_min0   = m0;
        wr_alm_en = en;
        cyc(1);
        wr_en     = 1'b0;
        wr_alm_en = 1'b0;
    endtask

    task automatic wr_time(input int h, input int m);
        logic [12:0] v;
        v = bcd(h, m);
        wr(3'd0, v[12:11], v[10:7], v[6:4], v[3:0], 1'b0);
    endtask

    task automatic wr_alm(input int slot, input int h, input int m, input logic en);
        logic [12:0] v;
        v = bcd(h, m);
        wr(3'(slot + 1), v[12:11], v[10:7], v[6:4], v[3:0], en);
    endtask

    task automatic pulse(input logic s, input logic p);
        snooze = s;
        stop   = p;
        cyc(1);
        snooze = 1'b0;
        stop   = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected end of stimulus");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_hr1 = '0; wr_hr0 = '0;
        wr_min1 = '0; wr_min0 = '0; wr_alm_en = 1'b0; snooze = 1'b0; stop = 1'b0;

        // Reset values and prescaler starting at 0.
        push("reset", bcd(0, 0), 1'b0, 1'b1, 2'd0, 1'b0);
        cyc(2);
        rst = 1'b0;
        sb_pop();
        push_idle("presc_hold", bcd(0, 0));
        cyc(3);
        sb_pop();
        push_idle("presc_tick", bcd(0, 1));
        cyc(1);
        sb_pop();

        // Rollover boundaries.
        push_idle("w2359", bcd(23, 59)); wr_time(23, 59); sb_pop();
        push_idle("roll_0000", bcd(0, 0)); cyc(4); sb_pop();
        push_idle("w0959", bcd(9, 59)); wr_time(9, 59); sb_pop();
        push_idle("roll_1000", bcd(10, 0)); cyc(4); sb_pop();
        push_idle("w1959", bcd(19, 59)); wr_time(19, 59); sb_pop();
        push_idle("roll_2000", bcd(20, 0)); cyc(4); sb_pop();

        // Invalid writes leave the time untouched.
        push_idle("w1234", bcd(12, 34)); wr_time(12, 34); sb_pop();
        push_idle("bad_24", bcd(12, 34)); wr(3'd0, 2'd2, 4'd4, 3'd0, 4'd0, 1'b0); sb_pop();
        push_idle("bad_60", bcd(12, 34)); wr(3'd0, 2'd1, 4'd2, 3'd6, 4'd0, 1'b0); sb_pop();
        push_idle("bad_bcd", bcd(12, 34)); wr(3'd0, 2'd1, 4'd2, 3'd3, 4'hA, 1'b0); sb_pop();

        // Out-of-range alarm address must not arm any slot.
        wr(3'd5, 2'd0, 4'd7, 3'd0, 4'd1, 1'b1);
        push_idle("w0700", bcd(7, 0)); wr_time(7, 0); sb_pop();
        push_idle("addr5_nomatch", bcd(7, 1)); cyc(4); sb_pop();

        // Priority: slots 1 and 3 both at 07:01, slot 0 at 07:02.
        wr_alm(3, 7, 1, 1'b1);
        wr_alm(1, 7, 1, 1'b1);
        wr_alm(0, 7, 2, 1'b1);
        push_idle("w0700b", bcd(7, 0)); wr_time(7, 0); sb_pop();
        push_idle("pre_match", bcd(7, 0)); cyc(3); sb_pop();
        push("prio", bcd(7, 1), 1'b1, 1'b1, 2'd1, 1'b0); cyc(1); sb_pop();

        // Snooze, re-ring after 2 ticks (07:02 match ignored), auto-silence after 3.
        push("snz_enter", bcd(7, 1), 1'b0, 1'b1, 2'd1, 1'b1); pulse(1'b1, 1'b0); sb_pop();
        push("snz_hold", bcd(7, 2), 1'b0, 1'b1, 2'd1, 1'b1); cyc(6); sb_pop();
        push("rering", bcd(7, 3), 1'b1, 1'b1, 2'd1, 1'b0); cyc(1); sb_pop();
        push("ring_hold", bcd(7, 5), 1'b1, 1'b1, 2'd1, 1'b0); cyc(11); sb_pop();
        push_idle("auto_silence", bcd(7, 6)); cyc(1); sb_pop();

        // stop and snooze together while ringing.
        wr_alm(2, 7, 7, 1'b1);
        push("ring2", bcd(7, 7), 1'b1, 1'b1, 2'd2, 1'b0); cyc(3); sb_pop();
        push_idle("stop_snz", bcd(7, 7)); pulse(1'b1, 1'b1); sb_pop();

        // Disabling another slot keeps ringing; disabling the ringing slot stops it.
        push_idle("w0706", bcd(7, 6)); wr_time(7, 6); sb_pop();
        push("ring2b", bcd(7, 7), 1'b1, 1'b1, 2'd2, 1'b0); cyc(4); sb_pop();
        push("other_off", bcd(7, 7), 1'b1, 1'b1, 2'd2, 1'b0); wr_alm(0, 7, 2, 1'b0); sb_pop();
        push_idle("slot_off", bcd(7, 7)); wr_alm(2, 7, 7, 1'b0); sb_pop();

        // Time write in a tick cycle: write wins, no match, prescaler restarts.
        wr_alm(0, 11, 11, 1'b1);
        push_idle("w1000", bcd(10, 0)); wr_time(10, 0); sb_pop();
        cyc(3);
        push_idle("wr_tick", bcd(11, 11)); wr_time(11, 11); sb_pop();
        push_idle("wr_tick_hold", bcd(11, 11)); cyc(3); sb_pop();
        push_idle("wr_tick_next", bcd(11, 12)); cyc(1); sb_pop();

        // Reset during SNOOZE clears time, status and alarms.
        wr_alm(1, 11, 13, 1'b1);
        push("ring3", bcd(11, 13), 1'b1, 1'b1, 2'd1, 1'b0); cyc(3); sb_pop();
        push("snz2", bcd(11, 13), 1'b0, 1'b1, 2'd1, 1'b1); pulse(1'b1, 1'b0); sb_pop();
        push("rst_mid", bcd(0, 0), 1'b0, 1'b1, 2'd0, 1'b0);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        sb_pop();
        push_idle("w1110", bcd(11, 10)); wr_time(11, 10); sb_pop();
        push("alm_cleared", bcd(11, 11), 1'b0, 1'b1, 2'd0, 1'b0); cyc(4); sb_pop();

        if (sb_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_leftover: got %0d entries, expected 0", sb_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
